// File: rtl/cpuc_ctrl_pkg.sv
// Shared types and index map for the CPUC grid sequencer.
// The component order matches the grid's component_outputs concatenation.
package cpuc_ctrl_pkg;

    localparam int CPUC_NUM_OF_REGS   = 8;
    localparam int CPUC_NUM_OF_PC     = 1;
    localparam int CPUC_NUM_OF_ADDERS = 1;
    localparam int CPUC_NUM_OF_CMP    = 1;
    localparam int CPUC_NUM_OF_EQUAL  = 1;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int R = CPUC_NUM_OF_REGS + CPUC_NUM_OF_PC;
    localparam int C = R + CPUC_NUM_OF_ADDERS + CPUC_NUM_OF_CMP + CPUC_NUM_OF_EQUAL;

    localparam int ADDER_BASE = R;
    localparam int CMP_BASE   = ADDER_BASE + CPUC_NUM_OF_ADDERS;
    localparam int EQUAL_BASE = CMP_BASE + CPUC_NUM_OF_CMP;

    localparam int MAX_FU_COUNT =
        (CPUC_NUM_OF_ADDERS > CPUC_NUM_OF_CMP)
            ? ((CPUC_NUM_OF_ADDERS > CPUC_NUM_OF_EQUAL) ? CPUC_NUM_OF_ADDERS : CPUC_NUM_OF_EQUAL)
            : ((CPUC_NUM_OF_CMP > CPUC_NUM_OF_EQUAL) ? CPUC_NUM_OF_CMP : CPUC_NUM_OF_EQUAL);

    localparam int REG_IDX_W  = idx_w(R);
    // One spare code point so an out-of-range unit number is representable and rejectable.
    localparam int UNIT_IDX_W = $clog2(MAX_FU_COUNT + 1);

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_MOV = 3'd1,
        OP_ADD = 3'd2,
        OP_GT  = 3'd3,
        OP_EQ  = 3'd4
    } t_cpuc_opcode;

    typedef struct packed {
        logic [2:0]            opcode;
        logic [UNIT_IDX_W-1:0] unit;
        logic [REG_IDX_W-1:0]  dst;
        logic [REG_IDX_W-1:0]  src_a;
        logic [REG_IDX_W-1:0]  src_b;
    } t_cpuc_instr;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } t_cpuc_ctrl_state;

endpackage

// File: rtl/cpuc_ctrl_onehot_dec.sv
// Index to one-hot decoder with a global enable; all zeros when disabled.
module cpuc_onehot_dec
    import cpuc_ctrl_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             en_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [N-1:0]     onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int k = 0; k < N; k++) begin
            onehot_o[k] = en_i && (int'(idx_i) == k);
        end
    end

endmodule

// File: rtl/cpuc_ctrl.sv
// Sequences one micro-instruction at a time onto the CPUC grid tri-state enables,
// keeping every shared bus at zero or one driver per cycle.
module cpuc_ctrl
    import cpuc_ctrl_pkg::*;
#(
    parameter int NUM_OF_REGS   = CPUC_NUM_OF_REGS,
    parameter int NUM_OF_PC     = CPUC_NUM_OF_PC,
    parameter int NUM_OF_ADDERS = CPUC_NUM_OF_ADDERS,
    parameter int NUM_OF_CMP    = CPUC_NUM_OF_CMP,
    parameter int NUM_OF_EQUAL  = CPUC_NUM_OF_EQUAL,
    parameter int EXEC_CYCLES   = 1,
    localparam int NR = NUM_OF_REGS + NUM_OF_PC,
    localparam int NF = NUM_OF_ADDERS + NUM_OF_CMP + NUM_OF_EQUAL,
    localparam int NC = NR + NF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  t_cpuc_instr     instr,
    output logic [NR-1:0]   op_a_en,
    output logic [NR-1:0]   op_b_en,
    output logic [NF-1:0]   op_unit_en,
    output logic [NC-1:0]   comp_to_reg_en,
    output logic [NR-1:0]   reg_load_en,
    output logic            busy,
    output logic            instr_done,
    output logic            illegal_op
);

    localparam int CNT_W  = idx_w(EXEC_CYCLES);
    localparam int FU_W   = idx_w(NF);
    localparam int CIDX_W = idx_w(NC);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

    t_cpuc_ctrl_state state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    t_cpuc_instr      instr_q, instr_d;
    logic             illegal_d;

    logic ready_q, busy_q, done_q, illegal_q;
    logic [NR-1:0] op_a_q, op_b_q, load_q;
    logic [NF-1:0] unit_q;
    logic [NC-1:0] comp_q;

    logic [NR-1:0] op_a_dec, op_b_dec, load_dec;
    logic [NF-1:0] unit_dec;
    logic [NC-1:0] comp_dec;

    logic              is_alu, opnd_en, write_en;
    logic [FU_W-1:0]   fu_idx;
    logic [CIDX_W-1:0] comp_idx;

    function automatic logic instr_legal(input t_cpuc_instr i);
        logic ok;
        ok = (int'(i.dst) < NR) && (int'(i.src_a) < NR) && (int'(i.src_b) < NR);
        case (i.opcode)
            OP_NOP, OP_MOV: ;
            OP_ADD:  ok = ok && (int'(i.unit) < NUM_OF_ADDERS);
            OP_GT:   ok = ok && (int'(i.unit) < NUM_OF_CMP);
            OP_EQ:   ok = ok && (int'(i.unit) < NUM_OF_EQUAL);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid && ready_q) begin
                    if (instr_legal(instr)) begin
                        instr_d = instr;
                        case (instr.opcode)
                            OP_NOP:  state_d = ST_DONE;
                            OP_MOV:  state_d = ST_WRITE;
                            default: begin
                                state_d = ST_DRIVE;
                                cnt_d   = CNT_LOAD;
                            end
                        endcase
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) state_d = ST_WRITE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_WRITE: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Enables are decoded from the next state so the registered copies switch exactly at state entry.
    always_comb begin
        is_alu   = (instr_d.opcode == OP_ADD) || (instr_d.opcode == OP_GT) || (instr_d.opcode == OP_EQ);
        opnd_en  = is_alu && ((state_d == ST_DRIVE) || (state_d == ST_WRITE));
        write_en = (state_d == ST_WRITE);
        fu_idx   = '0;
        case (instr_d.opcode)
            OP_ADD:  fu_idx = FU_W'(int'(instr_d.unit));
            OP_GT:   fu_idx = FU_W'(NUM_OF_ADDERS + int'(instr_d.unit));
            OP_EQ:   fu_idx = FU_W'(NUM_OF_ADDERS + NUM_OF_CMP + int'(instr_d.unit));
            default: ;
        endcase
        comp_idx = is_alu ? CIDX_W'(NR + int'(fu_idx)) : CIDX_W'(int'(instr_d.src_a));
    end

    cpuc_onehot_dec #(.N(NR), .IDX_W(REG_IDX_W)) u_dec_a (
        .en_i(opnd_en), .idx_i(instr_d.src_a), .onehot_o(op_a_dec));
    cpuc_onehot_dec #(.N(NR), .IDX_W(REG_IDX_W)) u_dec_b (
        .en_i(opnd_en), .idx_i(instr_d.src_b), .onehot_o(op_b_dec));
    cpuc_onehot_dec #(.N(NF), .IDX_W(FU_W)) u_dec_unit (
        .en_i(opnd_en), .idx_i(fu_idx), .onehot_o(unit_dec));
    cpuc_onehot_dec #(.N(NC), .IDX_W(CIDX_W)) u_dec_comp (
        .en_i(write_en), .idx_i(comp_idx), .onehot_o(comp_dec));
    cpuc_onehot_dec #(.N(NR), .IDX_W(REG_IDX_W)) u_dec_load (
        .en_i(write_en), .idx_i(instr_d.dst), .onehot_o(load_dec));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            unit_q    <= '0;
            comp_q    <= '0;
            load_q    <= '0;
        end else begin
            ready_q   <= (state_d == ST_IDLE);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            illegal_q <= illegal_d;
            op_a_q    <= op_a_dec;
            op_b_q    <= op_b_dec;
            unit_q    <= unit_dec;
            comp_q    <= comp_dec;
            load_q    <= load_dec;
        end
    end

    assign instr_ready    = ready_q;
    assign busy           = busy_q;
    assign instr_done     = done_q;
    assign illegal_op     = illegal_q;
    assign op_a_en        = op_a_q;
    assign op_b_en        = op_b_q;
    assign op_unit_en     = unit_q;
    assign comp_to_reg_en = comp_q;
    assign reg_load_en    = load_q;

endmodule

// File: tb/tb_cpuc_ctrl.sv
// Bench for cpuc_ctrl: vector table, hand sequences and random traffic against a frame-list model.
module tb_cpuc_ctrl;
    import cpuc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        valid, valid3;
    t_cpuc_instr instr, instr3;
    logic        ready, busy, done, ill;
    logic [8:0]  a_en, b_en, load;
    logic [2:0]  u_en;
    logic [11:0] comp;
    logic        ready3, busy3, done3, ill3;
    logic [8:0]  a3, b3, load3;
    logic [2:0]  u3;
    logic [11:0] comp3;

    cpuc_ctrl #(.EXEC_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .instr_valid(valid), .instr_ready(ready), .instr(instr),
        .op_a_en(a_en), .op_b_en(b_en), .op_unit_en(u_en), .comp_to_reg_en(comp),
        .reg_load_en(load), .busy(busy), .instr_done(done), .illegal_op(ill));

    cpuc_ctrl #(.EXEC_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .instr_valid(valid3), .instr_ready(ready3), .instr(instr3),
        .op_a_en(a3), .op_b_en(b3), .op_unit_en(u3), .comp_to_reg_en(comp3),
        .reg_load_en(load3), .busy(busy3), .instr_done(done3), .illegal_op(ill3));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic t_cpuc_instr mk(input int op, input int u, input int d, input int a, input int b);
        t_cpuc_instr r;
        r.opcode = 3'(op);
        r.unit   = UNIT_IDX_W'(u);
        r.dst    = REG_IDX_W'(d);
        r.src_a  = REG_IDX_W'(a);
        r.src_b  = REG_IDX_W'(b);
        return r;
    endfunction

    // Reference: each accepted instruction expands into the list of output frames it produces.
    typedef struct packed {
        logic        ready, busy, done, ill;
        logic [8:0]  a, b;
        logic [2:0]  u;
        logic [11:0] comp;
        logic [8:0]  load;
    } frame_t;

    frame_t cur = '0;
    frame_t fq[$];

    function automatic void model_accept(input t_cpuc_instr i);
        int op, u, d, sa, sb, fu;
        frame_t f;
        op = int'(i.opcode); u = int'(i.unit); d = int'(i.dst);
        sa = int'(i.src_a);  sb = int'(i.src_b);
        f = '0;
        if (op > 4 || d >= 9 || sa >= 9 || sb >= 9 || (op >= 2 && u >= 1)) begin
            f.ready = 1'b1;
            f.ill   = 1'b1;
            fq.push_back(f);
            return;
        end
        if (op >= 2) begin
            fu = (op == 2) ? u : (op == 3) ? 1 + u : 2 + u;
            f.busy = 1'b1;
            f.a = 9'b1 << sa;
            f.b = 9'b1 << sb;
            f.u = 3'b1 << fu;
            fq.push_back(f);
            f.comp = 12'b1 << (9 + fu);
            f.load = 9'b1 << d;
            fq.push_back(f);
        end else if (op == 1) begin
            f.busy = 1'b1;
            f.comp = 12'b1 << sa;
            f.load = 9'b1 << d;
            fq.push_back(f);
        end
        f = '0;
        f.busy = 1'b1;
        f.done = 1'b1;
        fq.push_back(f);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            fq.delete();
            cur = '0;
        end else begin
            if (cur.ready && valid) model_accept(instr);
            if (fq.size() > 0) cur = fq.pop_front();
            else begin
                cur = '0;
                cur.ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        frame_t act;
        if (rst) begin
            act = {ready, busy, done, ill, a_en, b_en, u_en, comp, load};
            check("trace", 64'(act), 64'(cur));
            check("bus_onehot", {$onehot0(a_en), $onehot0(b_en), $onehot0(u_en), $onehot0(comp),
                                 (comp == '0) || (load != '0)}, 5'b11111);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 20) begin
            step();
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL wait_ready actual=0 required=1 at %0t", $time);
        end
    endtask

    typedef struct {
        int op, u, d, sa, sb;
        int lat;
        logic [11:0] comp;
        logic [8:0]  load;
        bit ill;
    } vec_t;

    localparam int NV = 12;
    vec_t tv[NV];

    initial begin
        int lat;
        logic [11:0] s_comp;
        logic [8:0]  s_load;
        logic ill1, rdy1, en1;
        int dones[$];
        int n_done;

        tv[0]  = '{2, 0, 3, 1, 2, 3, 12'h200, 9'h008, 1'b0};
        tv[1]  = '{1, 0, 5, 0, 0, 2, 12'h001, 9'h020, 1'b0};
        tv[2]  = '{0, 0, 0, 0, 0, 1, 12'h000, 9'h000, 1'b0};
        tv[3]  = '{3, 0, 8, 7, 7, 3, 12'h400, 9'h100, 1'b0};
        tv[4]  = '{4, 0, 1, 1, 0, 3, 12'h800, 9'h002, 1'b0};
        tv[5]  = '{6, 0, 0, 0, 0, 0, 12'h000, 9'h000, 1'b1};
        tv[6]  = '{5, 0, 1, 1, 1, 0, 12'h000, 9'h000, 1'b1};
        tv[7]  = '{7, 0, 0, 0, 0, 0, 12'h000, 9'h000, 1'b1};
        tv[8]  = '{2, 0, 9, 1, 2, 0, 12'h000, 9'h000, 1'b1};
        tv[9]  = '{1, 0, 1, 15, 0, 0, 12'h000, 9'h000, 1'b1};
        tv[10] = '{2, 1, 1, 1, 2, 0, 12'h000, 9'h000, 1'b1};
        tv[11] = '{1, 0, 8, 3, 0, 2, 12'h008, 9'h100, 1'b0};

        rst = 1'b0; valid = 1'b0; valid3 = 1'b0; instr = '0; instr3 = '0;
        repeat (2) step();
        check("rst_ready", ready, 0);
        check("rst_busy_done_ill", {busy, done, ill}, 0);
        check("rst_enables", {a_en, b_en, u_en, comp, load}, 0);
        check("rst_ready3", ready3, 0);
        rst = 1'b1;
        step();
        check("ready_after_release", ready, 1);
        check("ready3_after_release", ready3, 1);

        for (int t = 0; t < NV; t++) begin
            wait_ready();
            valid = 1'b1;
            instr = mk(tv[t].op, tv[t].u, tv[t].d, tv[t].sa, tv[t].sb);
            step();
            valid = 1'b0;
            ill1 = ill; rdy1 = ready; en1 = |{a_en, b_en, u_en, comp, load};
            lat = 0; s_comp = '0; s_load = '0;
            for (int k = 1; k <= 8 && lat == 0; k++) begin
                if (load != '0) begin
                    s_comp = comp;
                    s_load = load;
                end
                if (done) lat = k;
                if (lat == 0) step();
            end
            if (tv[t].ill) begin
                check($sformatf("vec%0d_illegal_pulse", t), ill1, 1);
                check($sformatf("vec%0d_illegal_ready", t), rdy1, 1);
                check($sformatf("vec%0d_illegal_noen", t), en1, 0);
                check($sformatf("vec%0d_illegal_nodone", t), lat, 0);
            end else begin
                check($sformatf("vec%0d_latency", t), lat, tv[t].lat);
                check($sformatf("vec%0d_comp", t), s_comp, tv[t].comp);
                check($sformatf("vec%0d_load", t), s_load, tv[t].load);
            end
        end

        // Back-to-back: valid held high over three ADDs.
        wait_ready();
        valid = 1'b1;
        instr = mk(2, 0, 3, 1, 2);
        for (int c = 1; c <= 11; c++) begin
            step();
            if (done) dones.push_back(c);
        end
        valid = 1'b0;
        check("b2b_count", dones.size(), 3);
        if (dones.size() == 3) begin
            check("b2b_done0", dones[0], 3);
            check("b2b_done1", dones[1], 7);
            check("b2b_done2", dones[2], 11);
        end

        // Reset during DRIVE aborts without a done pulse.
        wait_ready();
        valid = 1'b1;
        instr = mk(2, 0, 3, 1, 2);
        step();
        valid = 1'b0;
        check("abort_pre_opa", a_en, 9'h002);
        rst = 1'b0;
        #1;
        check("abort_enables", {a_en, b_en, u_en, comp, load}, 0);
        check("abort_busy_ready", {busy, ready}, 0);
        step();
        step();
        rst = 1'b1;
        step();
        check("abort_ready_after", ready, 1);
        n_done = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) n_done++;
            step();
        end
        check("abort_no_done", n_done, 0);

        // EQ on the three-cycle operand-settle instance.
        check("eq3_ready", ready3, 1);
        valid3 = 1'b1;
        instr3 = mk(4, 0, 2, 4, 5);
        step();
        valid3 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            logic [43:0] exp;
            if (c <= 3)      exp = {9'h010, 9'h020, 3'b100, 12'h000, 9'h000, 1'b1, 1'b0};
            else if (c == 4) exp = {9'h010, 9'h020, 3'b100, 12'h800, 9'h004, 1'b1, 1'b0};
            else             exp = {9'h000, 9'h000, 3'b000, 12'h000, 9'h000, 1'b1, 1'b1};
            check($sformatf("eq3_cycle%0d", c), {a3, b3, u3, comp3, load3, busy3, done3}, exp);
            step();
        end

        for (int c = 0; c < 400; c++) begin
            int op;
            op = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7);
            valid = 1'($urandom_range(0, 1));
            instr = mk(op, ($urandom_range(0, 9) == 0) ? 1 : 0,
                       ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8),
                       ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8),
                       ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8));
            step();
        end
        valid = 1'b0;
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpuc_ctrl.md
Name: cpuc_ctrl

Overview:
Sequencer for the CPUC component grid. It accepts one micro-instruction at a time over a valid/ready handshake and drives the grid's tri-state enables in a fixed order:
- register-to-operand enables,
- then component-to-register-bus enables plus the destination register load.

It guarantees that each shared bus has at most one driver in every cycle. It sits beside the grid at the cpuc top level and replaces the currently unconnected `.en()` pins.

Parameters:
- NUM_OF_REGS, 8, general registers
- NUM_OF_PC, 1, PC registers, indexed after the general registers
- NUM_OF_ADDERS, 1, adder instances
- NUM_OF_CMP, 1, '>' instances
- NUM_OF_EQUAL, 1, '==' instances
- EXEC_CYCLES, 1, operand settle cycles before write (≥1)
- Derived, not overridable: R = NUM_OF_REGS+NUM_OF_PC; C = R+NUM_OF_ADDERS+NUM_OF_CMP+NUM_OF_EQUAL

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- instr  in  t_cpuc_instr  {opcode[2:0], unit, dst, src_a, src_b}
- op_a_en  out  R  one-hot; register driving operand-A bus of selected unit type
- op_b_en  out  R  one-hot; register driving operand-B bus
- op_unit_en  out  C-R  one-hot; which functional unit's operand tri-states are enabled
- comp_to_reg_en  out  C  one-hot; component driving the register-input bus
- reg_load_en  out  R  one-hot; destination register load strobe
- busy  out  1  instruction in flight
- instr_done  out  1  one-cycle pulse on completion
- illegal_op  out  1  one-cycle pulse on rejected instruction

Behaviour:
- Component index map: regs 0..R-1, adders R.., CMP next, EQUAL last. This matches the component_outputs concatenation order.
- Opcodes:
  - 0 NOP
  - 1 MOV (dst ← src_a)
  - 2 ADD
  - 3 GT
  - 4 EQ
  - 5–7 illegal
- States: IDLE, DRIVE, WRITE, DONE. State register is 2 bits, encoding from the package.
- Reset (rst=0, async):
  - state=IDLE
  - all enable vectors 0
  - busy=0, instr_done=0, illegal_op=0
  - latched instruction cleared
  - instr_ready=0 while rst is low, 1 from the first cycle after release
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready the instruction is latched.
  - ADD/GT/EQ → DRIVE.
  - MOV → WRITE.
  - NOP → DONE.
  - Illegal opcode, any index ≥ R, or unit ≥ count of its type → illegal_op pulse next cycle, stay IDLE, no enables asserted.
- DRIVE:
  - Asserted for exactly EXEC_CYCLES cycles (down-counter): op_a_en[src_a], op_b_en[src_b], op_unit_en[unit offset within FU range].
  - Then → WRITE.
- WRITE, one cycle:
  - Operand enables held from DRIVE.
  - comp_to_reg_en[unit component index] asserted; for MOV this is src_a.
  - reg_load_en[dst] asserted.
  - Then → DONE.
- DONE, one cycle:
  - All enables 0.
  - instr_done=1.
  - → IDLE.
- busy=1 in DRIVE/WRITE/DONE. instr_ready=0 whenever busy.
- Outputs are registered, decoded from the next state, so enables appear glitch-free at state entry.
- Latency from the accept edge to the instr_done cycle:
  - ADD/GT/EQ: EXEC_CYCLES+2
  - MOV: 2
  - NOP: 1
- Bus invariant: each enable vector is zero or one-hot in every cycle; comp_to_reg_en is never set without reg_load_en.
- Operand overlap: src_a==src_b drives both buses from the same register (legal). dst equal to a source is legal; the register loads the old-value-based result at the WRITE edge.
- Destination may be the PC index (R-1); no implicit PC increment.
- instr changing while not accepted: ignored. instr_valid held high while busy: accepted on the first IDLE cycle.
- rst asserted mid-instruction: enables drop asynchronously; the instruction is aborted and no instr_done pulse is generated.

Decomposition:
- cpuc_package additions:
  - t_cpuc_opcode enum
  - t_cpuc_instr packed struct
  - t_cpuc_ctrl_state enum
  - derived localparams R, C, REG_IDX_W=$clog2(R), UNIT_IDX_W
  - component base offsets ADDER_BASE, CMP_BASE, EQUAL_BASE
- One sub-module: cpuc_onehot_dec, parameterised index→one-hot with enable, instantiated per enable vector.

Test Plan:
- Reset: hold rst=0 mid-DRIVE of ADD → all enables 0 immediately, busy=0; release → instr_ready=1, no instr_done.
- ADD r3←r1+r2, EXEC_CYCLES=1, unit 0: accept at cycle 0.
  - Cycle 1: op_a_en=0x002, op_b_en=0x004, op_unit_en[0]=1.
  - Cycle 2: comp_to_reg_en[9]=1, reg_load_en=0x008.
  - Cycle 3: instr_done=1.
- MOV r5←r0 → cycle 1: comp_to_reg_en=0x001, reg_load_en=0x020, no op enables; cycle 2: done.
- EQ with opcode 4, unit 0, EXEC_CYCLES=3 → DRIVE lasts 3 cycles, comp_to_reg_en[11]=1 in WRITE, done at accept+5.
- Illegal: opcode 6, or dst=9 with R=9 → illegal_op pulse, all enables 0, instr_ready stays 1.
- Back-to-back: instr_valid held high with 3 ADDs → accepted every 4 cycles; one-hot/zero checker assertion on every enable vector passes each cycle.
